dbg_mem_arbiter: RTL and testbench
==================================

Name: dbg_mem_arbiter

Overview:
- Shares the MCU's single data-memory port between the CPU load/store unit and the UART debugger controller.
- Accepts one-shot debug memory commands (controller mem_rd/mem_wr with out_valid) and queues one of them.
- Arbitrates each debug command against CPU traffic with bounded starvation.
- Sequences the fixed-latency memory and returns a busy/data handshake the controller polls as mcu_busy.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from read issue to mem_rdata valid; legal 1..4.
- DBG_STARVE, 8, CPU grants a pending debug request may lose before it wins arbitration.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dbg_req  in  1  one-cycle command pulse
- dbg_we  in  1  1=write
- dbg_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_rdata  out  DATA_W  last debug read result, held
- dbg_busy  out  1  command outstanding; drives controller mcu_busy
- dbg_err  out  1  one-cycle pulse, command rejected
- cpu_req  in  1  level; held with its fields until cpu_gnt
- cpu_we  in  1  CPU write enable
- cpu_size  in  2  CPU access size
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_size  out  2  memory access size
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset values: state S_IDLE; dbg_pend=0; starve_cnt=0; lat_cnt=0; dbg_rdata=0; dbg_err=0.
- While rst_n is low, mem_en, cpu_gnt and cpu_rvalid are forced 0, and any in-flight read is discarded.
- Debug command capture:
  - dbg_req with legal size and alignment (half: addr[0]=0; word: addr[1:0]=0) and dbg_pend=0 latches we/size/addr/wdata and sets dbg_pend.
  - dbg_req with illegal size, misalignment, or dbg_pend=1 is dropped; dbg_err pulses in the next cycle.
- dbg_busy is combinational: dbg_req | dbg_pend | (state==S_DBG_RD).
- States:
  - S_IDLE: the only state that issues. Debug wins if dbg_pend & (!cpu_req | starve_cnt==DBG_STARVE); otherwise the CPU is issued if cpu_req. A dbg_req arriving this cycle is not yet pending, so the CPU wins that cycle.
  - Issue cycle T: mem_en=1 and mem_* fields are driven combinationally from the winner.
  - A CPU issue also asserts cpu_gnt in cycle T.
  - A debug issue clears dbg_pend and starve_cnt at the end of T.
  - starve_cnt increments, saturating at DBG_STARVE, on each CPU issue while dbg_pend=1.
- Writes: complete in cycle T; next state S_IDLE.
- Reads:
  - Next state is S_CPU_RD or S_DBG_RD, and lat_cnt counts cycles T+1..T+MEM_LAT.
  - In cycle T+MEM_LAT: for a CPU read, cpu_rvalid=1 and cpu_rdata=mem_rdata combinationally; for a debug read, dbg_rdata is registered from mem_rdata at the end of that cycle.
  - S_IDLE is re-entered at T+MEM_LAT+1, and no issue occurs during S_*_RD.
- Debug timing: for a write, dbg_busy falls in cycle T+1; for a read, dbg_busy falls at T+MEM_LAT+1 with dbg_rdata already valid. This meets the controller rule of polling busy the cycle after out_valid.
- dbg_rdata is unchanged by writes, errors and CPU traffic.
- Reset asserted mid-read: the outstanding read never completes and dbg_busy drops immediately.

Decomposition:
- Shared package dbg_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - arb_state_t enum {S_IDLE, S_CPU_RD, S_DBG_RD}
  - a function aligned(size, addr[1:0]) returning legal/illegal
- No sub-module: one FSM plus capture registers, roughly 180 lines.

Test Plan:
- CPU idle; dbg word read at 0x100, mem returns 0xDEADBEEF, MEM_LAT=2 -> mem_en in cycle T=req+1, dbg_busy high for cycles req..T+2, dbg_rdata=0xDEADBEEF at T+3, busy low at T+3.
- cpu_req held high continuously, with CPU reads and dbg byte write to 0x3 -> debug issued after exactly DBG_STARVE=8 CPU grants; mem_we=1, mem_size=0, mem_addr=0x3.
- cpu_req and dbg_req rise in the same cycle -> cpu_gnt first; debug issues in the first S_IDLE after that CPU access completes.
- dbg_req word at 0x102, size=3, and a second dbg_req while pending -> dbg_err pulse each time, no mem_en for those commands, dbg_pend unchanged.
- rst_n low during S_DBG_RD -> dbg_busy, mem_en and cpu_rvalid are 0 immediately; after release, state is S_IDLE and dbg_rdata=0.
- MEM_LAT=1, back-to-back CPU reads -> cpu_rvalid one cycle after each cpu_gnt; next cpu_gnt no earlier than 2 cycles after the previous one.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared encodings and helpers for the debug/CPU data-memory arbiter.
package dbg_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CPU_RD,
    S_DBG_RD
  } arb_state_t;

  // Legal size with natural alignment of the low address bits.
  function automatic logic aligned(input logic [1:0] size, input logic [1:0] a);
    logic ok;
    case (size_t'(size))
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~a[0];
      SZ_WORD: ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dbg_mem_arbiter.sv
// Arbitrates the single data-memory port between the CPU LSU and one queued
// debug command, sequencing fixed-latency reads.
module dbg_mem_arbiter
  import dbg_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int DBG_STARVE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [1:0]        dbg_size,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_busy,
  output logic              dbg_err,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(DBG_STARVE + 1);

  arb_state_t        state, state_nxt;
  logic              dbg_pend;
  logic              p_we;
  logic [1:0]        p_size;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic [SW-1:0]     starve_cnt;
  logic [2:0]        lat_cnt;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              dbg_err_q;

  logic dbg_ok, dbg_win, cpu_win, rd_done;

  assign dbg_ok  = dbg_req & aligned(dbg_size, dbg_addr[1:0]) & ~dbg_pend;
  assign dbg_win = (state == S_IDLE) & dbg_pend &
                   (~cpu_req | (starve_cnt == SW'(DBG_STARVE)));
  assign cpu_win = (state == S_IDLE) & ~dbg_win & cpu_req;
  assign rd_done = (state != S_IDLE) & (lat_cnt == 3'(MEM_LAT));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (dbg_win && !p_we)      state_nxt = S_DBG_RD;
        else if (cpu_win && !cpu_we) state_nxt = S_CPU_RD;
      end
      S_CPU_RD, S_DBG_RD: if (rd_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dbg_pend    <= 1'b0;
      p_we        <= 1'b0;
      p_size      <= '0;
      p_addr      <= '0;
      p_wdata     <= '0;
      starve_cnt  <= '0;
      lat_cnt     <= '0;
      dbg_rdata_q <= '0;
      dbg_err_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      dbg_err_q <= dbg_req & ~dbg_ok;

      if (state == S_IDLE && state_nxt != S_IDLE) lat_cnt <= 3'd1;
      else if (state != S_IDLE)                   lat_cnt <= rd_done ? 3'd0 : lat_cnt + 3'd1;

      // dbg_ok needs !dbg_pend and dbg_win needs dbg_pend, so these never collide.
      if (dbg_win)     dbg_pend <= 1'b0;
      else if (dbg_ok) dbg_pend <= 1'b1;

      if (dbg_ok) begin
        p_we    <= dbg_we;
        p_size  <= dbg_size;
        p_addr  <= dbg_addr;
        p_wdata <= dbg_wdata;
      end

      if (dbg_win)
        starve_cnt <= '0;
      else if (cpu_win && dbg_pend && starve_cnt != SW'(DBG_STARVE))
        starve_cnt <= starve_cnt + 1'b1;

      if (state == S_DBG_RD && rd_done) dbg_rdata_q <= mem_rdata;
    end
  end

  assign mem_en     = rst_n & (dbg_win | cpu_win);
  assign mem_we     = dbg_win ? p_we    : cpu_we;
  assign mem_size   = dbg_win ? p_size  : cpu_size;
  assign mem_addr   = dbg_win ? p_addr  : cpu_addr;
  assign mem_wdata  = dbg_win ? p_wdata : cpu_wdata;
  assign cpu_gnt    = rst_n & cpu_win;
  assign cpu_rvalid = rst_n & (state == S_CPU_RD) & rd_done;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_err    = dbg_err_q;
  assign dbg_busy   = rst_n & (dbg_req | dbg_pend | (state == S_DBG_RD));

endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// Directed bench: u1 runs MEM_LAT=1, u2 runs MEM_LAT=2, both share stimulus.
module tb_dbg_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dbg_req, dbg_we, cpu_req, cpu_we;
  logic [1:0]  dbg_size, cpu_size;
  logic [31:0] dbg_addr, dbg_wdata, cpu_addr, cpu_wdata;

  logic        cpu_gnt1, cpu_rvalid1, mem_en1, mem_we1, dbg_busy1, dbg_err1;
  logic [1:0]  mem_size1;
  logic [31:0] cpu_rdata1, mem_addr1, mem_wdata1, mem_rdata1, dbg_rdata1;
  logic        cpu_gnt2, cpu_rvalid2, mem_en2, mem_we2, dbg_busy2, dbg_err2;
  logic [1:0]  mem_size2;
  logic [31:0] cpu_rdata2, mem_addr2, mem_wdata2, mem_rdata2, dbg_rdata2;
  logic [31:0] a1_d1, a2_d1, a2_d2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {~a[15:0], a[15:0]};
  endfunction

  always @(posedge clk) begin
    a1_d1 <= mem_addr1;
    a2_d1 <= mem_addr2;
    a2_d2 <= a2_d1;
  end
  assign mem_rdata1 = mem_fn(a1_d1);
  assign mem_rdata2 = mem_fn(a2_d2);

  dbg_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .DBG_STARVE(8)) u1 (
    .clk(clk), .rst_n(rst_n), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata1), .dbg_busy(dbg_busy1),
    .dbg_err(dbg_err1), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt1), .cpu_rvalid(cpu_rvalid1),
    .cpu_rdata(cpu_rdata1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_size(mem_size1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1));

  dbg_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .DBG_STARVE(8)) u2 (
    .clk(clk), .rst_n(rst_n), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata2), .dbg_busy(dbg_busy2),
    .dbg_err(dbg_err2), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt2), .cpu_rvalid(cpu_rvalid2),
    .cpu_rdata(cpu_rdata2), .mem_en(mem_en2), .mem_we(mem_we2), .mem_size(mem_size2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_cmd(input logic we, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d);
    dbg_req = 1'b1; dbg_we = we; dbg_size = sz; dbg_addr = a; dbg_wdata = d;
  endtask

  typedef struct {
    logic [1:0] size;
    logic [1:0] off;
    logic       exp_err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int gcnt, last_gnt, rv_cnt, en_cnt;
    logic found;

    vecs[0]  = '{2'd0, 2'd0, 1'b0};
    vecs[1]  = '{2'd0, 2'd3, 1'b0};
    vecs[2]  = '{2'd1, 2'd0, 1'b0};
    vecs[3]  = '{2'd1, 2'd1, 1'b1};
    vecs[4]  = '{2'd1, 2'd2, 1'b0};
    vecs[5]  = '{2'd1, 2'd3, 1'b1};
    vecs[6]  = '{2'd2, 2'd0, 1'b0};
    vecs[7]  = '{2'd2, 2'd1, 1'b1};
    vecs[8]  = '{2'd2, 2'd2, 1'b1};
    vecs[9]  = '{2'd2, 2'd3, 1'b1};
    vecs[10] = '{2'd3, 2'd0, 1'b1};

    rst_n = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_size = '0; dbg_addr = '0; dbg_wdata = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'd2; cpu_addr = '0; cpu_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en", mem_en1, 0);
    chk("rst_busy", dbg_busy1, 0);
    chk("rst_err", dbg_err1, 0);
    chk("rst_rdata", dbg_rdata1, 0);
    tick(); rst_n = 1'b1;
    tick();

    // Debug word read at 0x100 with MEM_LAT=2 (u2)
    dbg_cmd(1'b0, 2'd2, 32'h100, 32'h0);
    @(negedge clk); chk("rd_busy_R", dbg_busy2, 1);
    tick(); dbg_req = 1'b0;
    @(negedge clk);
    chk("rd_en_T", mem_en2, 1);
    chk("rd_addr_T", mem_addr2, 32'h100);
    chk("rd_we_T", mem_we2, 0);
    chk("rd_busy_T", dbg_busy2, 1);
    tick(); @(negedge clk);
    chk("rd_en_T1", mem_en2, 0);
    chk("rd_busy_T1", dbg_busy2, 1);
    tick(); @(negedge clk);
    chk("rd_busy_T2", dbg_busy2, 1);
    chk("rd_data_T2", dbg_rdata2, 0);
    tick(); @(negedge clk);
    chk("rd_busy_T3", dbg_busy2, 0);
    chk("rd_data_T3", dbg_rdata2, 32'hDEADBEEF);
    chk("rd_data_lat1", dbg_rdata1, 32'hDEADBEEF);
    repeat (2) tick();

    // Capture legality table on u1
    foreach (vecs[i]) begin
      dbg_cmd(1'b1, vecs[i].size, 32'h400 | {30'd0, vecs[i].off}, 32'hA0 + i);
      tick(); dbg_req = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_err", i), dbg_err1, vecs[i].exp_err);
      chk($sformatf("vec%0d_en", i), mem_en1, !vecs[i].exp_err);
      chk($sformatf("vec%0d_busy", i), dbg_busy1, !vecs[i].exp_err);
      if (!vecs[i].exp_err) begin
        chk($sformatf("vec%0d_size", i), mem_size1, vecs[i].size);
        chk($sformatf("vec%0d_addr", i), mem_addr1, 32'h400 | {30'd0, vecs[i].off});
      end
      repeat (3) tick();
    end

    // Starvation bound: CPU reads held, debug byte write to 0x3
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    repeat (3) tick();
    dbg_cmd(1'b1, 2'd0, 32'h3, 32'h5A);
    tick(); dbg_req = 1'b0;
    gcnt = 0; found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (mem_en1 && mem_we1) begin
        found = 1'b1;
        chk("starve_grants", gcnt, 8);
        chk("starve_size", mem_size1, 0);
        chk("starve_addr", mem_addr1, 32'h3);
        chk("starve_nognt", cpu_gnt1, 0);
      end else if (cpu_gnt1) gcnt++;
      tick();
    end
    chk("starve_found", found, 1);
    cpu_req = 1'b0;
    repeat (6) tick();

    // CPU and debug request in the same cycle
    cpu_req = 1'b1; cpu_addr = 32'h40;
    dbg_cmd(1'b1, 2'd2, 32'h200, 32'h77);
    @(negedge clk);
    chk("same_gnt", cpu_gnt1, 1);
    chk("same_we", mem_we1, 0);
    tick(); dbg_req = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    chk("same_rd_en", mem_en1, 0);
    chk("same_rvalid", cpu_rvalid1, 1);
    chk("same_rdata", cpu_rdata1, mem_fn(32'h40));
    tick(); @(negedge clk);
    chk("same_dbg_en", mem_en1, 1);
    chk("same_dbg_we", mem_we1, 1);
    chk("same_dbg_addr", mem_addr1, 32'h200);
    repeat (6) tick();

    // Second command while pending is rejected, first is kept
    cpu_req = 1'b1; cpu_addr = 32'h44;
    repeat (2) tick();
    dbg_cmd(1'b1, 2'd2, 32'h10, 32'h11112222);
    tick(); dbg_req = 1'b0;
    @(negedge clk); chk("pend1_err", dbg_err1, 0);
    repeat (2) tick();
    dbg_cmd(1'b1, 2'd2, 32'h20, 32'h33334444);
    tick(); dbg_req = 1'b0;
    @(negedge clk);
    chk("pend2_err", dbg_err1, 1);
    chk("pend2_busy", dbg_busy1, 1);
    tick(); cpu_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (mem_en1 && mem_we1) begin
        found = 1'b1;
        chk("pend_addr", mem_addr1, 32'h10);
        chk("pend_wdata", mem_wdata1, 32'h11112222);
      end
      tick();
    end
    chk("pend_found", found, 1);
    en_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_en1) en_cnt++;
      tick();
    end
    chk("pend_no_extra", en_cnt, 0);
    chk("pend_busy_done", dbg_busy1, 0);

    // Back-to-back CPU reads, MEM_LAT=1 (u1)
    cpu_req = 1'b1; cpu_addr = 32'h80;
    last_gnt = -1; rv_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (cpu_gnt1) begin
        if (last_gnt >= 0) chk("b2b_gap", c - last_gnt, 2);
        last_gnt = c;
      end
      if (cpu_rvalid1) begin
        rv_cnt++;
        chk("b2b_rv_lat", c - last_gnt, 1);
        chk("b2b_rdata", cpu_rdata1, mem_fn(32'h80));
      end
      tick();
    end
    chk("b2b_rv_cnt", rv_cnt, 6);
    cpu_req = 1'b0;
    repeat (4) tick();
    chk("rdata_held", dbg_rdata1, 32'hDEADBEEF);

    // Reset during a debug read on u2
    dbg_cmd(1'b0, 2'd2, 32'h20, 32'h0);
    tick(); dbg_req = 1'b0;
    @(negedge clk); chk("rr_en_T", mem_en2, 1);
    tick(); @(negedge clk); chk("rr_busy_pre", dbg_busy2, 1);
    rst_n = 1'b0;
    #1;
    chk("rr_busy", dbg_busy2, 0);
    chk("rr_en", mem_en2, 0);
    chk("rr_rvalid", cpu_rvalid2, 0);
    chk("rr_rdata_clr", dbg_rdata2, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("rr_rdata_after", dbg_rdata2, 0);
    chk("rr_busy_after", dbg_busy2, 0);
    tick();
    dbg_cmd(1'b1, 2'd2, 32'h30, 32'h99);
    tick(); dbg_req = 1'b0;
    @(negedge clk);
    chk("rr_idle_en", mem_en2, 1);
    chk("rr_idle_we", mem_we2, 1);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
